// File: rtl/rate_div_ctrl.sv
// rtl/rate_div_ctrl.sv - run/stop/single-step controller for a switch-selected clock divider
// Optional feature macro: RDC_PERIOD_CNT_EN adds the period_cnt output (ticks since last return to IDLE).
module rate_div_ctrl #(
    parameter int FAST_DIV = 1_000,
    parameter int MID_DIV  = 1_000_000,
    parameter int SLOW_DIV = 100_000_000,
    parameter int CW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    sw,
    input  logic          run,
    input  logic          step,
    output logic          clk_out,
    output logic          tick,
    output logic [CW-1:0] div_cur,
    output logic [1:0]    state
`ifdef RDC_PERIOD_CNT_EN
    ,
    output logic [15:0]   period_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CW-1:0] FAST_V  = CW'(FAST_DIV);
    localparam logic [CW-1:0] MID_V   = CW'(MID_DIV);
    localparam logic [CW-1:0] SLOW_V  = CW'(SLOW_DIV);
    localparam logic [CW-1:0] MIN_DIV = CW'(2);
    localparam logic [CW-1:0] ONE     = CW'(1);

    // A divisor below 2 would give a zero half-period; force it to the smallest legal value.
    function automatic logic [CW-1:0] clamp_div(input logic [CW-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    sw_meta;
    logic [2:0]    sw_sync;
    logic [CW-1:0] sw_dec;
    logic [CW-1:0] pending;
    logic [CW-1:0] counter;
    logic [CW-1:0] half;
    logic [CW-1:0] half_m1;
    logic          active;
    logic          at_end;
    logic          fall_now;
    logic          go_idle;
    logic          rise_now;
    logic          load_div;

    assign state   = state_q;
    assign half    = div_cur >> 1;
    assign half_m1 = half - ONE;
    assign active  = (state_q != S_IDLE);
    assign at_end  = active && (counter == half_m1);
    assign fall_now = at_end && clk_out;

    // Two-flop synchronizer for the asynchronous rate switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= 3'b000;
            sw_sync <= 3'b000;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Switch code to divisor lookup.
    always_comb begin
        sw_dec = SLOW_V;
        case (sw_sync)
            3'b010:  sw_dec = FAST_V;
            3'b100:  sw_dec = MID_V;
            default: sw_dec = SLOW_V;
        endcase
    end

    // Pending divisor register; only copied into div_cur at a safe boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= SLOW_V;
        end else begin
            pending <= sw_dec;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A drain that starts exactly on a period boundary has nothing left to finish.
                if (run) begin
                    state_d = S_RUN;
                end else if (fall_now) begin
                    state_d = S_IDLE;
                end else if (!clk_out && (counter == '0)) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                if (fall_now) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode: datapath controls derived from state and boundary detection.
    always_comb begin
        go_idle  = 1'b0;
        rise_now = 1'b0;
        load_div = 1'b0;
        if (active && (state_d == S_IDLE)) begin
            go_idle = 1'b1;
        end
        // A rising edge on the way back to IDLE would be a runt, so it is suppressed.
        if (at_end && !clk_out && !go_idle) begin
            rise_now = 1'b1;
        end
        if (!active || rise_now) begin
            load_div = 1'b1;
        end
    end

    // Half-period counter and divided clock; both parked at zero outside an active period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            clk_out <= 1'b0;
        end else if (!active || go_idle) begin
            counter <= '0;
            clk_out <= 1'b0;
        end else if (at_end) begin
            counter <= '0;
            clk_out <= ~clk_out;
        end else begin
            counter <= counter + ONE;
        end
    end

    // Divisor in effect: follows pending while idle, otherwise changes only on a rising toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cur <= SLOW_V;
        end else if (load_div) begin
            div_cur <= clamp_div(pending);
        end
    end

    // One-cycle tick coinciding with the first high cycle of clk_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= 1'b0;
        end else begin
            tick <= rise_now;
        end
    end

`ifdef RDC_PERIOD_CNT_EN
    // Count of completed ticks, restarted whenever the divider goes quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= 16'd0;
        end else if (go_idle) begin
            period_cnt <= 16'd0;
        end else if (tick) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule
